// File: rtl/bram_burst_reader.sv
// bram_burst_reader: streaming read master for one BRAM port.
// Takes a (base byte address, word count) command, issues sequential word
// reads, absorbs the 1-cycle BRAM read latency and delivers the words in
// address order on a valid/ready stream through a small return FIFO.
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   start, base_addr, word_cnt command strobe (accepted only when idle) and payload
//   busy, done                 command in progress / 1-cycle completion pulse
//   bram_en, bram_addr         read issue and byte address
//   bram_W_req, bram_W_data    write side, tied off (read-only master)
//   bram_R_data                read data, valid the cycle after bram_en
//   out_valid, out_data        stream output (FIFO head)
//   out_ready                  downstream accept
module bram_burst_reader #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_cnt,
   output logic              busy,
   output logic              done,
   output logic              bram_en,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [3:0]        bram_W_req,
   output logic [DATA_W-1:0] bram_W_data,
   input  logic [DATA_W-1:0] bram_R_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready
);

   localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned FCNT_W = PTR_W + 1;
   localparam int unsigned OCC_W  = PTR_W + 2;
   localparam int unsigned SUM_W  = CNT_W + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t              state, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0]    issued_q, issued_d;
   logic [CNT_W-1:0]    sent_q, sent_d;
   logic                inflight;
   logic                busy_d, done_d, en_d;
   logic [ADDR_W-1:0]   addr_d;

   logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
   logic [DATA_W-1:0]   mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr, wr_ptr_d, rd_ptr, rd_ptr_d;
   logic [FCNT_W-1:0]   fifo_cnt, fifo_cnt_d;
   logic                valid_d;
   logic [DATA_W-1:0]   data_d;

   logic                pop, push, room;
   logic [OCC_W-1:0]    occ;

   // Read-only master: write side tied off.
   assign bram_W_req  = 4'b0000;
   assign bram_W_data = '0;

   assign pop  = out_valid & out_ready;
   assign push = inflight;

   // Entries committed after this edge: stored + arriving now + issued now - leaving now.
   // Issuing next cycle is safe only if that still leaves a free slot.
   assign occ  = OCC_W'(fifo_cnt) + OCC_W'(inflight) + OCC_W'(bram_en) - OCC_W'(pop);
   assign room = occ < OCC_W'(FIFO_DEPTH);

   // Return FIFO next state; head is registered straight onto out_data.
   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr;
      rd_ptr_d   = rd_ptr;
      if (push) begin
         mem_d[wr_ptr] = bram_R_data;
         wr_ptr_d      = wr_ptr + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr + PTR_W'(1);
      end
      fifo_cnt_d = fifo_cnt + FCNT_W'(push) - FCNT_W'(pop);
      valid_d    = (fifo_cnt_d != '0);
      data_d     = mem_d[rd_ptr_d];
   end

   // Command FSM next state and registered-output next values.
   always_comb begin
      state_d  = state;
      cnt_d    = cnt_q;
      issued_d = issued_q;
      sent_d   = sent_q;
      en_d     = 1'b0;
      addr_d   = bram_addr;
      case (state)
         IDLE: begin
            if (start) begin
               cnt_d    = word_cnt;
               issued_d = '0;
               sent_d   = '0;
               addr_d   = base_addr & ~ADDR_W'(3);
               if (word_cnt == '0) begin
                  // Empty command: one idle DRAIN cycle, then done, no BRAM access.
                  state_d = DRAIN;
               end else begin
                  en_d     = 1'b1;
                  issued_d = CNT_W'(1);
                  state_d  = (word_cnt == CNT_W'(1)) ? DRAIN : RUN;
               end
            end
         end
         RUN: begin
            sent_d = sent_q + CNT_W'(pop);
            if ((issued_q < cnt_q) && room) begin
               en_d     = 1'b1;
               addr_d   = bram_addr + ADDR_W'(4);
               issued_d = issued_q + CNT_W'(1);
               if (issued_d == cnt_q) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            sent_d = sent_q + CNT_W'(pop);
            if (({1'b0, sent_q} + SUM_W'(pop)) == {1'b0, cnt_q}) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt_q     <= '0;
         issued_q  <= '0;
         sent_q    <= '0;
         inflight  <= 1'b0;
         bram_en   <= 1'b0;
         bram_addr <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         mem_q     <= '{default: '0};
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fifo_cnt  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         state     <= state_d;
         cnt_q     <= cnt_d;
         issued_q  <= issued_d;
         sent_q    <= sent_d;
         inflight  <= bram_en;
         bram_en   <= en_d;
         bram_addr <= addr_d;
         busy      <= busy_d;
         done      <= done_d;
         mem_q     <= mem_d;
         wr_ptr    <= wr_ptr_d;
         rd_ptr    <= rd_ptr_d;
         fifo_cnt  <= fifo_cnt_d;
         out_valid <= valid_d;
         out_data  <= data_d;
      end
   end

endmodule

// File: tb/tb_bram_burst_reader.sv
// Bench for bram_burst_reader: BRAM model with word(addr) = (addr>>2) ^ key,
// command-level reference model checked every cycle, plus literal pins.
module tb_bram_burst_reader;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 16;
   localparam int DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [CNT_W-1:0]  word_cnt = '0;
   logic              busy, done, bram_en, out_valid;
   logic [ADDR_W-1:0] bram_addr;
   logic [3:0]        bram_W_req;
   logic [DATA_W-1:0] bram_W_data, out_data;
   logic [DATA_W-1:0] bram_R_data = '0;
   logic              out_ready = 1'b1;

   bram_burst_reader #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .word_cnt(word_cnt), .busy(busy), .done(done), .bram_en(bram_en),
      .bram_addr(bram_addr), .bram_W_req(bram_W_req), .bram_W_data(bram_W_data),
      .bram_R_data(bram_R_data), .out_valid(out_valid), .out_data(out_data),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] key = '0;
   int ready_mode = 0;
   int release_cyc = 0;

   // BRAM: one-cycle read latency; garbage on the bus when no read was issued.
   always @(posedge clk) begin
      if (bram_en) bram_R_data <= (bram_addr >> 2) ^ key;
      else         bram_R_data <= $urandom();
   end

   // Downstream ready pattern.
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         2:       out_ready = (cyc >= release_cyc);
         default: out_ready = 1'b0;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model state: one command at a time.
   logic        active = 1'b0;
   int          t_start = 0, t_last = 0, n_cnt = 0, n_iss = 0, n_sent = 0;
   logic [31:0] base_m = '0;
   logic        prev_hold = 1'b0;
   int          en_cyc_q[$];
   logic [31:0] addr_q[$];
   logic [31:0] data_q[$];
   int          first_valid_cyc = -1, valid_cnt = 0, done_cyc = -1;

   always @(negedge clk) begin
      logic        was_active, beat, fin, ok;
      logic [31:0] ea;
      if (!rst) begin
         active    = 1'b0;
         prev_hold = 1'b0;
      end else begin
         was_active = active;
         beat       = out_valid && out_ready;
         chk("tie_off", 32'((bram_W_req == 4'b0) && (bram_W_data == '0)), 32'(1));
         chk("busy", 32'(busy), 32'(active && (cyc > t_start)));
         fin = active && ((n_cnt == 0) ? (cyc == t_start + 2)
                                       : ((n_sent == n_cnt) && (cyc == t_last + 1)));
         chk("done", 32'(done), 32'(fin));
         if (fin) done_cyc = cyc;
         if (bram_en) begin
            ok = active && (cyc > t_start) && (n_iss < n_cnt);
            chk("issue_legal", 32'(ok), 32'(1));
            if (ok) begin
               ea = base_m + 32'(4 * n_iss);
               chk("bram_addr", bram_addr, ea);
               chk("no_overflow", 32'((n_iss - n_sent - int'(beat)) < DEPTH), 32'(1));
               en_cyc_q.push_back(cyc);
               addr_q.push_back(bram_addr);
               n_iss++;
            end
         end
         if (prev_hold) chk("valid_held", 32'(out_valid), 32'(1));
         if (out_valid) begin
            ok = active && (n_sent < n_cnt);
            chk("valid_in_cmd", 32'(ok), 32'(1));
            ea = ((base_m + 32'(4 * n_sent)) >> 2) ^ key;
            chk("out_data", out_data, ea);
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            valid_cnt++;
            if (beat) begin
               data_q.push_back(out_data);
               n_sent++;
               t_last = cyc;
            end
         end
         prev_hold = out_valid && !out_ready;
         if (fin) active = 1'b0;
         if (start && !was_active) begin
            active  = 1'b1;
            t_start = cyc;
            base_m  = base_addr & ~32'd3;
            n_cnt   = int'(word_cnt);
            n_iss   = 0;
            n_sent  = 0;
            t_last  = -10;
            en_cyc_q.delete();
            addr_q.delete();
            data_q.delete();
            first_valid_cyc = -1;
            valid_cnt = 0;
            done_cyc  = -1;
         end
      end
   end

   // Issue one command and wait (bounded) for its done pulse; optional ignored re-start.
   task automatic run_cmd(input logic [31:0] b, input int n, input int mode, input int rel,
                          input logic [31:0] k, input int restart, output int t0);
      int i;
      key        = k;
      ready_mode = mode;
      @(posedge clk); #1;
      t0          = cyc;
      release_cyc = cyc + rel;
      base_addr   = b;
      word_cnt    = CNT_W'(n);
      start       = 1'b1;
      for (i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         if (restart > 0 && cyc == t0 + restart) begin
            start = 1'b1; base_addr = 32'h0000_0000; word_cnt = CNT_W'(7);
         end else begin
            start = 1'b0; base_addr = $urandom(); word_cnt = CNT_W'($urandom());
         end
         if (done_cyc >= t0) break;
      end
      start = 1'b0;
      chk("done_reached", 32'(done_cyc >= t0), 32'(1));
      @(posedge clk); #1;
   endtask

   logic [31:0] t1_addr [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
   logic [31:0] t1_data [4] = '{32'h40, 32'h41, 32'h42, 32'h43};
   logic [31:0] t5_addr [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
   logic [31:0] t5_data [3] = '{32'h3FFF_FFFE, 32'h3FFF_FFFF, 32'h0000_0000};

   initial begin
      int t0, n, cnt_pre;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_bram_en", 32'(bram_en), 32'(0));
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_bram_addr", bram_addr, 32'h0);
      chk("rst_out_data", out_data, 32'h0);
      rst = 1'b1;
      repeat (2) @(posedge clk);

      // 1) basic 4-word burst with identity BRAM contents
      run_cmd(32'h100, 4, 0, 0, 32'h0, 0, t0);
      chk("t1_issues", 32'(addr_q.size()), 32'(4));
      chk("t1_words", 32'(data_q.size()), 32'(4));
      for (int i = 0; i < 4; i++) begin
         if (i < addr_q.size()) begin
            chk("t1_addr", addr_q[i], t1_addr[i]);
            chk("t1_en_cyc", 32'(en_cyc_q[i]), 32'(t0 + 1 + i));
         end
         if (i < data_q.size()) chk("t1_data", data_q[i], t1_data[i]);
      end
      chk("t1_first_valid", 32'(first_valid_cyc), 32'(t0 + 3));
      chk("t1_done_cyc", 32'(done_cyc), 32'(t0 + 7));

      // 2) zero-length command
      run_cmd(32'h200, 0, 0, 0, 32'h0, 0, t0);
      chk("t2_issues", 32'(addr_q.size()), 32'(0));
      chk("t2_valid_cnt", 32'(valid_cnt), 32'(0));
      chk("t2_done_cyc", 32'(done_cyc), 32'(t0 + 2));

      // 3) 16 words, downstream stalled for 10 cycles
      run_cmd(32'h1000, 16, 2, 10, $urandom(), 0, t0);
      cnt_pre = 0;
      foreach (en_cyc_q[i]) if (en_cyc_q[i] < t0 + 10) cnt_pre++;
      chk("t3_issues_stalled", 32'(cnt_pre), 32'(DEPTH));
      chk("t3_words", 32'(data_q.size()), 32'(16));

      // 4) 64 words with random backpressure, unaligned base
      run_cmd($urandom(), 64, 1, 0, $urandom(), 0, t0);
      chk("t4_words", 32'(data_q.size()), 32'(64));

      // 5) address wrap, second start mid-run ignored
      run_cmd(32'hFFFF_FFF8, 3, 0, 0, 32'h0, 2, t0);
      chk("t5_issues", 32'(addr_q.size()), 32'(3));
      chk("t5_words", 32'(data_q.size()), 32'(3));
      for (int i = 0; i < 3; i++) begin
         if (i < addr_q.size()) chk("t5_addr", addr_q[i], t5_addr[i]);
         if (i < data_q.size()) chk("t5_data", data_q[i], t5_data[i]);
      end
      chk("t5_done_cyc", 32'(done_cyc), 32'(t0 + 6));

      // 6) asynchronous reset with the FIFO half full
      key = $urandom();
      ready_mode = 2;
      @(posedge clk); #1;
      release_cyc = cyc + 1000;
      base_addr = 32'h4000; word_cnt = CNT_W'(16); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk("t6_busy", 32'(busy), 32'(0));
      chk("t6_done", 32'(done), 32'(0));
      chk("t6_bram_en", 32'(bram_en), 32'(0));
      chk("t6_out_valid", 32'(out_valid), 32'(0));
      chk("t6_bram_addr", bram_addr, 32'h0);
      chk("t6_out_data", out_data, 32'h0);
      @(posedge clk); #2;
      rst = 1'b1;
      run_cmd(32'h8000, 5, 0, 0, $urandom(), 0, t0);
      chk("t6_words", 32'(data_q.size()), 32'(5));
      chk("t6_done_cyc", 32'(done_cyc), 32'(t0 + 5 + 3));

      // random commands; full-rate ones also pin done latency
      for (int r = 0; r < 8; r++) begin
         n = $urandom_range(0, 20);
         if (r % 2 == 0) begin
            run_cmd($urandom(), n, 0, 0, $urandom(), 0, t0);
            chk("rnd_done_cyc", 32'(done_cyc), 32'((n == 0) ? t0 + 2 : t0 + n + 3));
         end else begin
            run_cmd($urandom(), n, 1, 0, $urandom(), 0, t0);
         end
         chk("rnd_words", 32'(data_q.size()), 32'(n));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
